// File: rtl/rx_tx_pkg.sv
// Shared constants, state encodings and helpers for the rx port arbiter.
package rx_tx_pkg;

  localparam int NUM_PORTS       = 4;
  localparam int DATA_WIDTH      = 8;
  localparam int MAX_FRAME_BYTES = 1522;

  localparam int PORT_W = $clog2(NUM_PORTS);
  localparam int BEAT_W = $clog2(MAX_FRAME_BYTES + 1);

  typedef logic [PORT_W-1:0] port_idx_t;
  typedef logic [BEAT_W-1:0] beat_cnt_t;

  // Arbiter states, kept as plain constants so older tools see a simple vector.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_XFER  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rx_port_arbiter_if.sv
// Bundle of the per-port rx handshakes and the forwarded downstream stream.
interface rx_port_arbiter_if;
  import rx_tx_pkg::*;

  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rx_data_i;
  logic [NUM_PORTS-1:0]                 rx_valid_i;
  logic [NUM_PORTS-1:0]                 rx_sof_i;
  logic [NUM_PORTS-1:0]                 rx_eof_i;
  logic [NUM_PORTS-1:0]                 rx_error_i;
  logic [NUM_PORTS-1:0][47:0]           rx_dst_mac_i;
  logic [NUM_PORTS-1:0][47:0]           rx_src_mac_i;
  logic [NUM_PORTS-1:0]                 rx_grant_o;

  logic [DATA_WIDTH-1:0] out_data_o;
  logic                  out_valid_o;
  logic                  out_sof_o;
  logic                  out_eof_o;
  logic                  out_error_o;
  port_idx_t             out_port_o;
  logic [47:0]           out_dst_mac_o;
  logic [47:0]           out_src_mac_o;
  logic                  out_ready_i;

  // Arbiter side.
  modport master (
    input  rx_data_i, rx_valid_i, rx_sof_i, rx_eof_i, rx_error_i,
    input  rx_dst_mac_i, rx_src_mac_i, out_ready_i,
    output rx_grant_o, out_data_o, out_valid_o, out_sof_o, out_eof_o,
    output out_error_o, out_port_o, out_dst_mac_o, out_src_mac_o
  );

  // Rx ports plus downstream consumer side.
  modport slave (
    output rx_data_i, rx_valid_i, rx_sof_i, rx_eof_i, rx_error_i,
    output rx_dst_mac_i, rx_src_mac_i, out_ready_i,
    input  rx_grant_o, out_data_o, out_valid_o, out_sof_o, out_eof_o,
    input  out_error_o, out_port_o, out_dst_mac_o, out_src_mac_o
  );

endinterface

// File: rtl/rx_port_arbiter_rr_picker.sv
// Combinational round-robin search: first set request after ptr_i, with wrap.
module rr_picker
  import rx_tx_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req_i,
  input  port_idx_t            ptr_i,
  output port_idx_t            idx_o,
  output logic                 hit_o
);

  // Scan farthest-first so the nearest request after ptr_i is written last.
  always_comb begin
    int j;
    j     = 0;
    idx_o = '0;
    hit_o = 1'b0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      j = (int'(ptr_i) + k) % NUM_PORTS;
      if (req_i[j]) begin
        idx_o = port_idx_t'(j);
        hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rx_port_arbiter.sv
// Frame-granular round-robin arbiter sharing the switch-memory write path
// between the rx ports, with length truncation and orphan-frame draining.
module rx_port_arbiter
  import rx_tx_pkg::*;
(
  input  logic               switch_clk,
  input  logic               switch_rst,
  rx_port_arbiter_if.master  bus,
  output logic [15:0]        drop_count_o
);

  logic [1:0]  state_q, state_d;
  port_idx_t   sel_q, sel_d;
  port_idx_t   rr_ptr_q, rr_ptr_d;
  beat_cnt_t   beat_q, beat_d;
  logic [15:0] drop_q, drop_d;

  logic [NUM_PORTS-1:0] sof_req, orphan_req, grant;
  port_idx_t            sof_idx, orphan_idx;
  logic                 sof_hit, orphan_hit;
  logic sel_valid, sel_sof, sel_eof, sel_err;
  logic in_xfer, accept, at_limit, out_valid;

  assign sof_req    = bus.rx_valid_i & bus.rx_sof_i;
  assign orphan_req = bus.rx_valid_i & ~bus.rx_sof_i;

  rr_picker u_pick_sof (
    .req_i (sof_req),
    .ptr_i (rr_ptr_q),
    .idx_o (sof_idx),
    .hit_o (sof_hit)
  );

  rr_picker u_pick_orphan (
    .req_i (orphan_req),
    .ptr_i (rr_ptr_q),
    .idx_o (orphan_idx),
    .hit_o (orphan_hit)
  );

  assign sel_valid = bus.rx_valid_i[sel_q];
  assign sel_sof   = bus.rx_sof_i[sel_q];
  assign sel_eof   = bus.rx_eof_i[sel_q];
  assign sel_err   = bus.rx_error_i[sel_q];
  assign in_xfer   = (state_q == ST_XFER);
  // Current beat is number MAX_FRAME_BYTES when MAX-1 beats were already taken.
  assign at_limit  = (beat_q == beat_cnt_t'(MAX_FRAME_BYTES - 1));

  // Grant follows downstream readiness while forwarding; flushing ignores it.
  always_comb begin
    grant = '0;
    if (state_q == ST_XFER)       grant[sel_q] = bus.out_ready_i;
    else if (state_q == ST_FLUSH) grant[sel_q] = 1'b1;
  end

  assign accept    = sel_valid & grant[sel_q];
  assign out_valid = in_xfer & sel_valid;

  assign bus.rx_grant_o    = grant;
  assign bus.out_valid_o   = out_valid;
  assign bus.out_data_o    = in_xfer ? bus.rx_data_i[sel_q] : '0;
  assign bus.out_sof_o     = out_valid & sel_sof;
  assign bus.out_eof_o     = out_valid & (sel_eof | at_limit);
  assign bus.out_error_o   = out_valid & (sel_err | (at_limit & ~sel_eof));
  assign bus.out_port_o    = sel_q;
  assign bus.out_dst_mac_o = bus.rx_dst_mac_i[sel_q];
  assign bus.out_src_mac_o = bus.rx_src_mac_i[sel_q];
  assign drop_count_o      = drop_q;

  // Next-state logic: pick in IDLE, forward in XFER, discard in FLUSH.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    beat_d   = beat_q;
    drop_d   = drop_q;
    case (state_q)
      ST_IDLE: begin
        if (sof_hit) begin
          sel_d   = sof_idx;
          beat_d  = '0;
          state_d = ST_XFER;
        end else if (orphan_hit) begin
          sel_d   = orphan_idx;
          drop_d  = sat_inc16(drop_q);
          state_d = ST_FLUSH;
        end
      end
      ST_XFER: begin
        if (accept) begin
          if (sel_eof) begin
            rr_ptr_d = sel_q;
            state_d  = ST_IDLE;
          end else if (at_limit) begin
            drop_d  = sat_inc16(drop_q);
            state_d = ST_FLUSH;
          end else begin
            beat_d = beat_q + beat_cnt_t'(1);
          end
        end
      end
      ST_FLUSH: begin
        if (accept && sel_eof) begin
          rr_ptr_d = sel_q;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset leaves the pointer so port 0 wins first.
  always_ff @(posedge switch_clk or posedge switch_rst) begin
    if (switch_rst) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      rr_ptr_q <= port_idx_t'(NUM_PORTS - 1);
      beat_q   <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
      drop_q   <= drop_d;
    end
  end

endmodule

// File: tb/tb_rx_port_arbiter.sv
// Directed bench for rx_port_arbiter: per-port source queues, output log.
module tb_rx_port_arbiter;
  import rx_tx_pkg::*;

  localparam int NP = NUM_PORTS;

  typedef struct packed {
    logic [7:0] d;
    logic       sof;
    logic       eof;
    logic       err;
  } beat_t;

  typedef struct packed {
    logic [7:0] d;
    logic       sof;
    logic       eof;
    logic       err;
    logic [1:0] port;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] drop_count;
  int          vectors = 0;
  int          miscompares = 0;
  logic        ready_cmd = 1'b1;

  beat_t          rxq [NP][$];
  rec_t           out_log[$];
  rec_t           exp_log[$];
  logic [NP-1:0]  g_log[$];
  logic           r_log[$];

  rx_port_arbiter_if bus();

  rx_port_arbiter dut (
    .switch_clk   (clk),
    .switch_rst   (rst),
    .bus          (bus),
    .drop_count_o (drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    out_log.delete();
    exp_log.delete();
    g_log.delete();
    r_log.delete();
  endtask

  task automatic push_frame(input int p, input int len, input logic [7:0] base, input bit with_sof);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.d   = base + 8'(k);
      b.sof = with_sof && (k == 0);
      b.eof = (k == len - 1);
      b.err = 1'b0;
      rxq[p].push_back(b);
    end
  endtask

  // Expected forwarded beats; cut < len means truncated at beat cut.
  task automatic exp_frame(input int p, input int len, input logic [7:0] base, input int cut);
    rec_t r;
    for (int k = 0; k < cut; k++) begin
      r.d    = base + 8'(k);
      r.sof  = (k == 0);
      r.eof  = (k == len - 1) || (k == cut - 1);
      r.err  = (cut < len) && (k == cut - 1);
      r.port = 2'(p);
      exp_log.push_back(r);
    end
  endtask

  // One clock: drive queue heads, sample away from the edge, pop accepted beats.
  task automatic step();
    logic [NP-1:0] acc;
    rec_t r;
    @(negedge clk);
    bus.out_ready_i = ready_cmd;
    for (int p = 0; p < NP; p++) begin
      if (rxq[p].size() > 0) begin
        bus.rx_valid_i[p] = 1'b1;
        bus.rx_data_i[p]  = rxq[p][0].d;
        bus.rx_sof_i[p]   = rxq[p][0].sof;
        bus.rx_eof_i[p]   = rxq[p][0].eof;
        bus.rx_error_i[p] = rxq[p][0].err;
      end else begin
        bus.rx_valid_i[p] = 1'b0;
        bus.rx_data_i[p]  = 8'h00;
        bus.rx_sof_i[p]   = 1'b0;
        bus.rx_eof_i[p]   = 1'b0;
        bus.rx_error_i[p] = 1'b0;
      end
    end
    #1;
    acc = bus.rx_grant_o & bus.rx_valid_i;
    g_log.push_back(bus.rx_grant_o);
    r_log.push_back(ready_cmd);
    if (bus.out_valid_o && bus.out_ready_i) begin
      r.d    = bus.out_data_o;
      r.sof  = bus.out_sof_o;
      r.eof  = bus.out_eof_o;
      r.err  = bus.out_error_o;
      r.port = bus.out_port_o;
      out_log.push_back(r);
    end
    @(posedge clk);
    for (int p = 0; p < NP; p++)
      if (acc[p]) void'(rxq[p].pop_front());
  endtask

  function automatic bit queues_empty();
    for (int p = 0; p < NP; p++)
      if (rxq[p].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_drain(input int budget, output int n, output bit timeout);
    n = 0;
    timeout = 1'b0;
    while (!queues_empty()) begin
      if (n >= budget) begin
        timeout = 1'b1;
        break;
      end
      step();
      n++;
    end
  endtask

  function automatic int count_diff();
    int d = 0;
    int m = (out_log.size() < exp_log.size()) ? out_log.size() : exp_log.size();
    for (int i = 0; i < m; i++)
      if (out_log[i] !== exp_log[i]) d++;
    d += (out_log.size() > exp_log.size()) ? out_log.size() - exp_log.size()
                                           : exp_log.size() - out_log.size();
    return d;
  endfunction

  task automatic test_reset();
    #2;
    vectors++;
    if (bus.rx_grant_o !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_grant actual=%b required=0000", bus.rx_grant_o);
    end
    vectors++;
    if ({bus.out_valid_o, bus.out_sof_o, bus.out_eof_o, bus.out_error_o, bus.out_data_o, bus.out_port_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs actual v%b s%b e%b x%b d%h p%0d required all zero",
               bus.out_valid_o, bus.out_sof_o, bus.out_eof_o, bus.out_error_o, bus.out_data_o, bus.out_port_o);
    end
    vectors++;
    if (drop_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_drop actual=%0d required=0", drop_count);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_frame();
    int n, g0, gx, diffs;
    bit to;
    clear_logs();
    push_frame(0, 64, 8'h00, 1'b1);
    exp_frame(0, 64, 8'h00, 64);
    run_drain(200, n, to);
    g0 = 0;
    gx = 0;
    foreach (g_log[i]) begin
      if (g_log[i] == 4'b0001) g0++;
      else if (g_log[i] != 4'b0000) gx++;
    end
    diffs = count_diff();
    vectors++;
    if (to) begin miscompares++; $display("FAIL single_timeout actual=expired required=drained"); end
    vectors++;
    if (n !== 65) begin miscompares++; $display("FAIL single_cycles actual=%0d required=65", n); end
    vectors++;
    if (out_log.size() !== 64) begin miscompares++; $display("FAIL single_beats actual=%0d required=64", out_log.size()); end
    vectors++;
    if (diffs !== 0) begin miscompares++; $display("FAIL single_sequence actual=%0d differing beats required=0", diffs); end
    vectors++;
    if (g0 !== 64) begin miscompares++; $display("FAIL single_grant0_cycles actual=%0d required=64", g0); end
    vectors++;
    if (gx !== 0) begin miscompares++; $display("FAIL single_other_grants actual=%0d required=0", gx); end
    if (g_log.size() > 0) begin
      vectors++;
      if (g_log[0] !== 4'b0000) begin miscompares++; $display("FAIL single_arb_latency actual=%b required=0000", g_log[0]); end
    end
    vectors++;
    if (bus.out_dst_mac_o !== 48'h0200_0000_0000 || bus.out_src_mac_o !== 48'h0400_0000_0000) begin
      miscompares++;
      $display("FAIL single_macs actual=%h/%h required=020000000000/040000000000", bus.out_dst_mac_o, bus.out_src_mac_o);
    end
  endtask

  task automatic test_simultaneous_sof();
    int n, diffs, last1, first3;
    bit to;
    clear_logs();
    push_frame(1, 8, 8'h10, 1'b1);
    push_frame(3, 8, 8'h30, 1'b1);
    exp_frame(1, 8, 8'h10, 8);
    exp_frame(3, 8, 8'h30, 8);
    run_drain(100, n, to);
    last1  = -1;
    first3 = -1;
    foreach (g_log[i]) begin
      if (g_log[i][1]) last1 = i;
      if (g_log[i][3] && first3 < 0) first3 = i;
    end
    diffs = count_diff();
    vectors++;
    if (to) begin miscompares++; $display("FAIL two_sof_timeout actual=expired required=drained"); end
    vectors++;
    if (diffs !== 0) begin miscompares++; $display("FAIL two_sof_sequence actual=%0d differing beats required=0", diffs); end
    vectors++;
    if (last1 !== 8) begin miscompares++; $display("FAIL two_sof_port1_eof_cycle actual=%0d required=8", last1); end
    vectors++;
    if (first3 !== 10) begin miscompares++; $display("FAIL two_sof_port3_first_grant actual=%0d required=10", first3); end
    vectors++;
    if (bus.out_dst_mac_o !== 48'h0200_0000_0003) begin
      miscompares++;
      $display("FAIL two_sof_dst_mac actual=%h required=020000000003", bus.out_dst_mac_o);
    end
  endtask

  task automatic test_back_to_back();
    int n, diffs, multi;
    bit to;
    clear_logs();
    for (int p = 0; p < NP; p++) begin
      push_frame(p, 4, 8'(p * 64), 1'b1);
      push_frame(p, 4, 8'(p * 64 + 16), 1'b1);
    end
    for (int f = 0; f < 2; f++)
      for (int p = 0; p < NP; p++)
        exp_frame(p, 4, 8'(p * 64 + f * 16), 4);
    run_drain(100, n, to);
    multi = 0;
    foreach (g_log[i])
      if ($countones(g_log[i]) > 1) multi++;
    diffs = count_diff();
    vectors++;
    if (to) begin miscompares++; $display("FAIL b2b_timeout actual=expired required=drained"); end
    vectors++;
    if (diffs !== 0) begin miscompares++; $display("FAIL b2b_order actual=%0d differing beats required=0", diffs); end
    vectors++;
    if (n !== 40) begin miscompares++; $display("FAIL b2b_cycles actual=%0d required=40", n); end
    vectors++;
    if (multi !== 0) begin miscompares++; $display("FAIL b2b_onehot actual=%0d multi-grant cycles required=0", multi); end
  endtask

  task automatic test_backpressure();
    int c, diffs, bad;
    clear_logs();
    push_frame(2, 20, 8'hA0, 1'b1);
    exp_frame(2, 20, 8'hA0, 20);
    c = 0;
    while (!queues_empty() && c < 100) begin
      ready_cmd = !(c >= 5 && c < 15);
      step();
      c++;
    end
    ready_cmd = 1'b1;
    bad = 0;
    foreach (g_log[i])
      if (!r_log[i] && g_log[i] != 4'b0000) bad++;
    diffs = count_diff();
    vectors++;
    if (c !== 31) begin miscompares++; $display("FAIL bp_cycles actual=%0d required=31", c); end
    vectors++;
    if (bad !== 0) begin miscompares++; $display("FAIL bp_grant_when_stalled actual=%0d cycles required=0", bad); end
    vectors++;
    if (diffs !== 0) begin miscompares++; $display("FAIL bp_sequence actual=%0d differing beats required=0", diffs); end
  endtask

  task automatic test_orphan_and_reset();
    int n, g2;
    bit to;
    clear_logs();
    push_frame(2, 5, 8'h50, 1'b0);
    run_drain(50, n, to);
    g2 = 0;
    foreach (g_log[i])
      if (g_log[i] == 4'b0100) g2++;
    vectors++;
    if (to) begin miscompares++; $display("FAIL orphan_timeout actual=expired required=drained"); end
    vectors++;
    if (out_log.size() !== 0) begin miscompares++; $display("FAIL orphan_forwarded actual=%0d beats required=0", out_log.size()); end
    vectors++;
    if (g2 !== 5) begin miscompares++; $display("FAIL orphan_drain_grants actual=%0d required=5", g2); end
    vectors++;
    if (drop_count !== 16'd1) begin miscompares++; $display("FAIL orphan_drop actual=%0d required=1", drop_count); end

    clear_logs();
    push_frame(0, 10, 8'h60, 1'b1);
    repeat (4) step();
    @(negedge clk);
    #1;
    vectors++;
    if (bus.rx_grant_o !== 4'b0001 || bus.out_valid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL midframe_state actual=grant %b valid %b required=grant 0001 valid 1", bus.rx_grant_o, bus.out_valid_o);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.rx_grant_o !== 4'b0000) begin miscompares++; $display("FAIL async_reset_grant actual=%b required=0000", bus.rx_grant_o); end
    vectors++;
    if ({bus.out_valid_o, bus.out_sof_o, bus.out_eof_o, bus.out_error_o, bus.out_data_o} !== '0) begin
      miscompares++;
      $display("FAIL async_reset_outputs actual v%b d%h required v0 d00", bus.out_valid_o, bus.out_data_o);
    end
    vectors++;
    if (drop_count !== 16'd0) begin miscompares++; $display("FAIL async_reset_drop actual=%0d required=0", drop_count); end
    for (int p = 0; p < NP; p++) rxq[p].delete();
    bus.rx_valid_i = '0;
    bus.rx_sof_i   = '0;
    bus.rx_eof_i   = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_truncate();
    int n, diffs, g1;
    bit to;
    clear_logs();
    push_frame(1, 1600, 8'h00, 1'b1);
    push_frame(2, 6, 8'h70, 1'b1);
    exp_frame(1, 1600, 8'h00, MAX_FRAME_BYTES);
    exp_frame(2, 6, 8'h70, 6);
    run_drain(2000, n, to);
    g1 = 0;
    foreach (g_log[i])
      if (g_log[i] == 4'b0010) g1++;
    diffs = count_diff();
    vectors++;
    if (to) begin miscompares++; $display("FAIL trunc_timeout actual=expired required=drained"); end
    vectors++;
    if (out_log.size() !== 1528) begin miscompares++; $display("FAIL trunc_beats actual=%0d required=1528", out_log.size()); end
    vectors++;
    if (diffs !== 0) begin miscompares++; $display("FAIL trunc_sequence actual=%0d differing beats required=0", diffs); end
    vectors++;
    if (g1 !== 1600) begin miscompares++; $display("FAIL trunc_port1_grants actual=%0d required=1600", g1); end
    vectors++;
    if (n !== 1608) begin miscompares++; $display("FAIL trunc_cycles actual=%0d required=1608", n); end
    vectors++;
    if (drop_count !== 16'd1) begin miscompares++; $display("FAIL trunc_drop actual=%0d required=1", drop_count); end
  endtask

  initial begin
    rst             = 1'b1;
    bus.rx_valid_i  = '0;
    bus.rx_sof_i    = '0;
    bus.rx_eof_i    = '0;
    bus.rx_error_i  = '0;
    bus.rx_data_i   = '0;
    bus.out_ready_i = 1'b1;
    for (int p = 0; p < NP; p++) begin
      bus.rx_dst_mac_i[p] = 48'h0200_0000_0000 | 48'(p);
      bus.rx_src_mac_i[p] = 48'h0400_0000_0000 | 48'(p);
    end
    test_reset();
    test_single_frame();
    test_simultaneous_sof();
    test_back_to_back();
    test_backpressure();
    test_orphan_and_reset();
    test_truncate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
